// File: rtl/frame_pkg.sv
// Shared types and constants for the frame timer and its configuration stage.
package frame_pkg;

    typedef struct packed {
        logic [2:0] m;
        logic [3:0] ss;
        logic [2:0] bw;
        logic       data_off;
    } cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam cfg_t CFG_RESET = '{m: 3'd1, ss: 4'd1, bw: 3'd0, data_off: 1'b0};

    // States in which the phase counter walks the frame grid.
    function automatic logic is_framing(input state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/cfg_stage.sv
// Single-entry pending configuration slot with valid/ready intake and commit drain.
module cfg_stage import frame_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  cfg_t cfg_in,
    input  logic commit,
    output logic ready,
    output logic full,
    output logic full_next,
    output cfg_t data
);

    logic load_s;

    assign load_s = valid & ready;

    // Occupancy one cycle ahead; the top uses it to time the registered applied pulse.
    always_comb begin
        full_next = load_s | (full & ~commit);
    end

    // Pending slot: a held entry is never overwritten since ready is low while full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full  <= 1'b0;
            ready <= 1'b1;
            data  <= CFG_RESET;
        end else begin
            full  <= full_next;
            ready <= ~full_next;
            if (load_s) begin
                data <= cfg_in;
            end
        end
    end

endmodule

// File: rtl/frame_timer.sv
// Frame grid generator with SOF strobes and boundary-aligned commit of staged config.
module frame_timer import frame_pkg::*; #(
    parameter int FRAME_LEN = 1000,
    parameter int RX_OFFSET = 16,
    parameter int PH_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_M,
    input  logic [3:0]  cfg_SS,
    input  logic [2:0]  cfg_BW,
    input  logic        cfg_data_off,
    output logic [2:0]  index_M,
    output logic [3:0]  index_SS,
    output logic [2:0]  index_BW,
    output logic        index_data_off,
    output logic        sof_tx,
    output logic        sof_rx,
    output logic        cfg_applied,
    output logic [15:0] frame_cnt
);

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(FRAME_LEN - 1);
    localparam logic [PH_W-1:0] RX_PH   = PH_W'(RX_OFFSET);

    state_t          state_r;
    state_t          state_nx_s;
    logic [PH_W-1:0] phase_r;
    logic [PH_W-1:0] phase_nx_s;
    logic [PH_W-1:0] phase_inc_s;
    logic            at_last_s;
    logic            commit_s;
    logic            pend_full_s;
    logic            pend_full_nx_s;
    cfg_t            pend_s;
    cfg_t            cfg_req_s;
    cfg_t            idx_r;
    logic            sof_tx_r;
    logic            sof_rx_r;
    logic            cfg_applied_r;
    logic [15:0]     frame_cnt_r;

    assign cfg_req_s   = '{m: cfg_M, ss: cfg_SS, bw: cfg_BW, data_off: cfg_data_off};
    assign at_last_s   = (phase_r == LAST_PH);
    assign phase_inc_s = at_last_s ? '0 : phase_r + PH_W'(1);
    assign commit_s    = pend_full_s & ((state_r == START) | (is_framing(state_r) & at_last_s));

    cfg_stage u_cfg_stage (
        .clk       (clk),
        .rst       (rst),
        .valid     (cfg_valid),
        .cfg_in    (cfg_req_s),
        .commit    (commit_s),
        .ready     (cfg_ready),
        .full      (pend_full_s),
        .full_next (pend_full_nx_s),
        .data      (pend_s)
    );

    // Next state and phase; a drain cancelled by en resumes without a phase jump.
    always_comb begin
        state_nx_s = state_r;
        phase_nx_s = phase_r;
        case (state_r)
            IDLE: begin
                phase_nx_s = '0;
                if (en) begin
                    state_nx_s = START;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                state_nx_s = RUN;
                phase_nx_s = '0;
            end
            RUN: begin
                phase_nx_s = phase_inc_s;
                if (en) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_nx_s = RUN;
                    phase_nx_s = phase_inc_s;
                end else if (at_last_s) begin
                    state_nx_s = IDLE;
                    phase_nx_s = '0;
                end else begin
                    state_nx_s = DRAIN;
                    phase_nx_s = phase_inc_s;
                end
            end
            default: begin
                state_nx_s = IDLE;
                phase_nx_s = '0;
            end
        endcase
    end

    // Strobes and the applied pulse are precomputed from next state so they align with phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            phase_r       <= '0;
            idx_r         <= CFG_RESET;
            sof_tx_r      <= 1'b0;
            sof_rx_r      <= 1'b0;
            cfg_applied_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
        end else begin
            state_r       <= state_nx_s;
            phase_r       <= phase_nx_s;
            sof_tx_r      <= (state_nx_s == RUN) && (phase_nx_s == '0);
            sof_rx_r      <= is_framing(state_nx_s) && (phase_nx_s == RX_PH);
            cfg_applied_r <= pend_full_nx_s &&
                             ((state_nx_s == START) ||
                              (is_framing(state_nx_s) && (phase_nx_s == LAST_PH)));
            if (commit_s) begin
                idx_r <= pend_s;
            end
            if (is_framing(state_r) && at_last_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    assign index_M        = idx_r.m;
    assign index_SS       = idx_r.ss;
    assign index_BW       = idx_r.bw;
    assign index_data_off = idx_r.data_off;
    assign sof_tx         = sof_tx_r;
    assign sof_rx         = sof_rx_r;
    assign cfg_applied    = cfg_applied_r;
    assign frame_cnt      = frame_cnt_r;

endmodule

// File: tb/tb_frame_timer.sv
// Scoreboard bench for frame_timer with FRAME_LEN=8, RX_OFFSET=3.
module tb_frame_timer;
    import frame_pkg::*;

    localparam logic [2:0] K_TX = 3'b100;
    localparam logic [2:0] K_RX = 3'b010;
    localparam logic [2:0] K_AP = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [2:0]  cfg_M = 3'd0;
    logic [3:0]  cfg_SS = 4'd0;
    logic [2:0]  cfg_BW = 3'd0;
    logic        cfg_data_off = 1'b0;
    logic        cfg_ready;
    logic [2:0]  index_M;
    logic [3:0]  index_SS;
    logic [2:0]  index_BW;
    logic        index_data_off;
    logic        sof_tx;
    logic        sof_rx;
    logic        cfg_applied;
    logic [15:0] frame_cnt;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [2:0]  kind;
        logic [10:0] idx;
        logic [15:0] fc;
    } ev_t;

    ev_t exp_q[$];

    frame_timer #(.FRAME_LEN(8), .RX_OFFSET(3), .PH_W(16)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_M(cfg_M), .cfg_SS(cfg_SS), .cfg_BW(cfg_BW), .cfg_data_off(cfg_data_off),
        .index_M(index_M), .index_SS(index_SS), .index_BW(index_BW),
        .index_data_off(index_data_off),
        .sof_tx(sof_tx), .sof_rx(sof_rx), .cfg_applied(cfg_applied),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [10:0] pk(input logic [2:0] m, input logic [3:0] ss,
                                       input logic [2:0] bw, input logic d);
        return {m, ss, bw, d};
    endfunction

    task automatic expect_ev(input int c, input logic [2:0] k, input logic [10:0] idx,
                             input logic [15:0] fc);
        ev_t e;
        e.cyc = c; e.kind = k; e.idx = idx; e.fc = fc;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_cfg(input logic v, input logic [2:0] m, input logic [3:0] ss,
                             input logic [2:0] bw, input logic d);
        cfg_valid = v; cfg_M = m; cfg_SS = ss; cfg_BW = bw; cfg_data_off = d;
    endtask

    // Monitor: every strobe/pulse pops the scoreboard; overdue expectations count as misses.
    always @(negedge clk) begin
        ev_t         e;
        logic [2:0]  k;
        logic [10:0] idx;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_event kind=%b expected at cyc %0d", e.kind, e.cyc);
        end
        if (rst && (sof_tx || sof_rx || cfg_applied)) begin
            k   = {sof_tx, sof_rx, cfg_applied};
            idx = {index_M, index_SS, index_BW, index_data_off};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event kind=%b at cyc %0d", k, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.kind != k || e.idx != idx || e.fc != frame_cnt) begin
                    errors++;
                    $display("FAIL event got cyc=%0d kind=%b idx=%h fc=%h expected cyc=%0d kind=%b idx=%h fc=%h",
                             cyc, k, idx, frame_cnt, e.cyc, e.kind, e.idx, e.fc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] i01, c1, c2, c3;
        i01 = pk(3'd1, 4'd1, 3'd0, 1'b0);
        c1  = pk(3'd4, 4'd9, 3'd2, 1'b1);
        c2  = pk(3'd2, 4'd5, 3'd1, 1'b0);
        c3  = pk(3'd3, 4'd2, 3'd3, 1'b1);

        #1 rst = 1'b0;
        #1;
        chk("rst_index_M", 32'(index_M), 32'd1);
        chk("rst_index_SS", 32'(index_SS), 32'd1);
        chk("rst_index_BW", 32'(index_BW), 32'd0);
        chk("rst_index_data_off", 32'(index_data_off), 32'd0);
        chk("rst_sof", 32'({sof_tx, sof_rx, cfg_applied}), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        goto(2);
        rst = 1'b1;

        expect_ev(12, K_TX, i01, 16'd0);
        expect_ev(15, K_RX, i01, 16'd0);
        expect_ev(20, K_TX, i01, 16'd1);
        expect_ev(23, K_RX, i01, 16'd1);
        expect_ev(27, K_AP, i01, 16'd1);
        expect_ev(28, K_TX, c1,  16'd2);
        expect_ev(31, K_RX, c1,  16'd2);
        expect_ev(35, K_AP, c1,  16'd2);
        expect_ev(36, K_TX, c2,  16'd3);
        expect_ev(39, K_RX, c2,  16'd3);

        goto(10);
        en = 1'b1;
        goto(20);
        chk("frame_cnt_first", 32'(frame_cnt), 32'd1);
        goto(22);
        chk("ready_before_load", 32'(cfg_ready), 32'd1);
        drive_cfg(1'b1, 3'd4, 4'd9, 3'd2, 1'b1);
        goto(23);
        chk("ready_after_load", 32'(cfg_ready), 32'd0);
        drive_cfg(1'b1, 3'd2, 4'd5, 3'd1, 1'b0);
        goto(27);
        chk("index_M_held", 32'(index_M), 32'd1);
        goto(28);
        chk("ready_after_commit", 32'(cfg_ready), 32'd1);
        chk("index_M_first", 32'(index_M), 32'd4);
        goto(29);
        chk("ready_second_load", 32'(cfg_ready), 32'd0);
        drive_cfg(1'b0, 3'd0, 4'd0, 3'd0, 1'b0);

        goto(37);
        en = 1'b0;
        expect_ev(47, K_AP, c2, 16'd4);
        expect_ev(48, K_TX, c3, 16'd4);
        expect_ev(51, K_RX, c3, 16'd4);
        goto(44);
        chk("drain_no_sof_tx", 32'(sof_tx), 32'd0);
        chk("drain_frame_cnt", 32'(frame_cnt), 32'd4);
        goto(45);
        chk("idle_ready", 32'(cfg_ready), 32'd1);
        drive_cfg(1'b1, 3'd3, 4'd2, 3'd3, 1'b1);
        goto(46);
        drive_cfg(1'b0, 3'd0, 4'd0, 3'd0, 1'b0);
        en = 1'b1;

        goto(52);
        drive_cfg(1'b1, 3'd7, 4'd15, 3'd7, 1'b1);
        goto(53);
        drive_cfg(1'b0, 3'd0, 4'd0, 3'd0, 1'b0);
        rst = 1'b0;
        #1;
        chk("async_index_M", 32'(index_M), 32'd1);
        chk("async_index_SS", 32'(index_SS), 32'd1);
        chk("async_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("async_frame_cnt", 32'(frame_cnt), 32'd0);
        expect_ev(58, K_TX, i01, 16'd0);
        expect_ev(61, K_RX, i01, 16'd0);
        expect_ev(66, K_TX, i01, 16'd1);
        expect_ev(69, K_RX, i01, 16'd1);
        expect_ev(74, K_TX, i01, 16'd0);
        expect_ev(77, K_RX, i01, 16'd0);
        goto(56);
        rst = 1'b1;

        goto(62);
        en = 1'b0;
        goto(63);
        en = 1'b1;

        goto(70);
        force dut.frame_cnt_r = 16'hFFFF;
        #1 release dut.frame_cnt_r;
        goto(71);
        chk("frame_cnt_preload", 32'(frame_cnt), 32'h0000_FFFF);
        goto(74);
        chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

        goto(80);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
